// File: rtl/update_apply_unit.sv
// Update apply unit: queues two-lane combined updates and applies them to the vertex
// value memory through a forwarded read-modify-write pipe. Define UPDATE_MIN_EN for min-apply.
module update_apply_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              InputValid_A,
  input  logic              InputValid_B,
  input  logic [DATA_W-1:0] InDestVid_A,
  input  logic [DATA_W-1:0] InDestVid_B,
  input  logic [DATA_W-1:0] InUpdate_A,
  input  logic [DATA_W-1:0] InUpdate_B,
  output logic              InReady,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              Idle,
  output logic [31:0]       ApplyCount
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned HIST  = RD_LAT + 1;
  localparam int unsigned LAST  = RD_LAT - 1;

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_upd  [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, wr_ptr_b;
  logic [CNT_W-1:0]  count;
  logic              push_a, push_b, pop;

  logic              st_v    [RD_LAT];
  logic [ADDR_W-1:0] st_addr [RD_LAT];
  logic [DATA_W-1:0] st_upd  [RD_LAT];

  logic              h_v    [HIST];
  logic [ADDR_W-1:0] h_addr [HIST];
  logic [DATA_W-1:0] h_val  [HIST];

  logic [DATA_W-1:0] old_val, result;
  logic              hit, busy;
  logic              unused_dest_hi;

  assign unused_dest_hi = ^{InDestVid_A[DATA_W-1:ADDR_W], InDestVid_B[DATA_W-1:ADDR_W]};

  // Two free slots guarantee both lanes fit regardless of their valids
  assign InReady     = (CNT_W'(FIFO_DEPTH) - count) >= CNT_W'(2);
  assign push_a      = InReady & InputValid_A;
  assign push_b      = InReady & InputValid_B;
  assign pop         = (count != '0);
  assign wr_ptr_b    = wr_ptr + PTR_W'(push_a);
  assign mem_rd_en   = pop;
  assign mem_rd_addr = q_addr[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_a) begin
      q_addr[wr_ptr] <= InDestVid_A[ADDR_W-1:0];
      q_upd[wr_ptr]  <= InUpdate_A;
    end
    if (push_b) begin
      q_addr[wr_ptr_b] <= InDestVid_B[ADDR_W-1:0];
      q_upd[wr_ptr_b]  <= InUpdate_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end
  end

  // Read-latency shadow: stage LAST lines up with mem_rd_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        st_v[k]    <= 1'b0;
        st_addr[k] <= '0;
        st_upd[k]  <= '0;
      end
    end else begin
      st_v[0]    <= pop;
      st_addr[0] <= mem_rd_addr;
      st_upd[0]  <= q_upd[rd_ptr];
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        st_v[k]    <= st_v[k-1];
        st_addr[k] <= st_addr[k-1];
        st_upd[k]  <= st_upd[k-1];
      end
    end
  end

  // Youngest matching result not yet visible in memory overrides the read data
  always_comb begin
    old_val = mem_rd_data;
    hit     = 1'b0;
    for (int unsigned k = 0; k < HIST; k++) begin
      if (!hit && h_v[k] && (h_addr[k] == st_addr[LAST])) begin
        old_val = h_val[k];
        hit     = 1'b1;
      end
    end
`ifdef UPDATE_MIN_EN
    result = (old_val < st_upd[LAST]) ? old_val : st_upd[LAST];
`else
    result = old_val + st_upd[LAST];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < HIST; k++) begin
        h_v[k]    <= 1'b0;
        h_addr[k] <= '0;
        h_val[k]  <= '0;
      end
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      ApplyCount  <= '0;
    end else begin
      mem_wr_en <= st_v[LAST];
      if (st_v[LAST]) begin
        h_v[0]      <= 1'b1;
        h_addr[0]   <= st_addr[LAST];
        h_val[0]    <= result;
        for (int unsigned k = 1; k < HIST; k++) begin
          h_v[k]    <= h_v[k-1];
          h_addr[k] <= h_addr[k-1];
          h_val[k]  <= h_val[k-1];
        end
        mem_wr_addr <= st_addr[LAST];
        mem_wr_data <= result;
        ApplyCount  <= ApplyCount + 32'd1;
      end
    end
  end

  always_comb begin
    busy = mem_wr_en;
    for (int unsigned k = 0; k < RD_LAT; k++) begin
      busy = busy | st_v[k];
    end
  end

  assign Idle = (count == '0) & ~busy;

endmodule

// File: tb/tb_update_apply_unit.sv
// Bench for update_apply_unit: random and directed updates against a sequential
// apply-in-order memory model, with a latency-accurate memory behind the DUT.
module tb_update_apply_unit;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned MEM_N  = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              InputValid_A, InputValid_B;
  logic [DATA_W-1:0] InDestVid_A, InDestVid_B, InUpdate_A, InUpdate_B;
  logic              InReady, mem_rd_en, mem_wr_en, Idle;
  logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
  logic [DATA_W-1:0] mem_rd_data, mem_wr_data;
  logic [31:0]       ApplyCount;

  update_apply_unit dut (
    .clk(clk), .rst_n(rst_n),
    .InputValid_A(InputValid_A), .InputValid_B(InputValid_B),
    .InDestVid_A(InDestVid_A), .InDestVid_B(InDestVid_B),
    .InUpdate_A(InUpdate_A), .InUpdate_B(InUpdate_B),
    .InReady(InReady),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .Idle(Idle), .ApplyCount(ApplyCount)
  );

  always #5 clk = ~clk;

  // Vertex memory: two-cycle read latency, read-during-write returns old data
  logic [31:0] mem [MEM_N];
  logic [31:0] rd_pipe0, rd_pipe1;
  logic        pl_en;
  logic [5:0]  pl_addr;
  logic [31:0] pl_data;
  assign mem_rd_data = rd_pipe1;

  always @(posedge clk) begin
    if (mem_rd_en) rd_pipe0 <= mem[6'(mem_rd_addr)];
    rd_pipe1 <= rd_pipe0;
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_wr_en) mem[6'(mem_wr_addr)] <= mem_wr_data;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_acc = 0;
  int          cyc = 0;
  bit          saw_low;
  logic [31:0] ref_mem [MEM_N];
  logic [47:0] exp_q [$];
  int          wr_cycles [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every DUT write must be the next write of the in-order model
  always @(negedge clk) begin
    logic [47:0] e;
    if (rst_n && mem_wr_en) begin
      wr_cycles.push_back(cyc);
      check("wr_pending", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_wr_addr), 64'(e[47:32]));
        check("wr_data", 64'(mem_wr_data), 64'(e[31:0]));
      end
    end
  end

  function automatic logic [31:0] mk_dest(input logic [5:0] a);
    return {16'($urandom), 10'd0, a};
  endfunction

  function automatic void model_apply(input logic [31:0] dest, input logic [31:0] upd);
    logic [5:0]  a;
    logic [31:0] nv;
    a = dest[5:0];
`ifdef UPDATE_MIN_EN
    nv = (ref_mem[a] < upd) ? ref_mem[a] : upd;
`else
    nv = ref_mem[a] + upd;
`endif
    ref_mem[a] = nv;
    exp_q.push_back({dest[15:0], nv});
    n_acc++;
  endfunction

  task automatic preload(input logic [5:0] a, input logic [31:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic preload_all();
    for (int i = 0; i < int'(MEM_N); i++) preload(6'(i), $urandom);
  endtask

  // Present one lane pair and hold it until the DUT samples it
  task automatic drive(input logic va, input logic [5:0] aa, input logic [31:0] ua,
                       input logic vb, input logic [5:0] ab, input logic [31:0] ub);
    logic [31:0] da, db;
    logic        rdy;
    bit          done;
    done = 0;
    da = mk_dest(aa);
    db = mk_dest(ab);
    InputValid_A = va; InDestVid_A = da; InUpdate_A = ua;
    InputValid_B = vb; InDestVid_B = db; InUpdate_B = ub;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = InReady;
      if (!rdy) saw_low = 1;
      @(posedge clk);
      if (rdy) begin
        if (va) model_apply(da, ua);
        if (vb) model_apply(db, ub);
        done = 1;
      end
      #1;
    end
    check("accepted", 64'(done), 1);
    InputValid_A = 1'b0;
    InputValid_B = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (Idle && exp_q.size() == 0) ok = 1;
    end
    check({tag, "_idle"}, 64'(ok), 1);
    check({tag, "_drained"}, 64'(exp_q.size()), 0);
    check({tag, "_apply_cnt"}, 64'(ApplyCount), 64'(n_acc));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inready"}, 64'(InReady), 1);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 0);
    check({tag, "_wr_en"}, 64'(mem_wr_en), 0);
    check({tag, "_wr_addr"}, 64'(mem_wr_addr), 0);
    check({tag, "_wr_data"}, 64'(mem_wr_data), 0);
    check({tag, "_idle"}, 64'(Idle), 1);
    check({tag, "_apply_cnt"}, 64'(ApplyCount), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    InputValid_A = 1'b0; InputValid_B = 1'b0;
    InDestVid_A = '0; InDestVid_B = '0; InUpdate_A = '0; InUpdate_B = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    #2;
    check_reset_outputs("por");
    #10;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    preload_all();

    // Single update latency: read next cycle, write three cycles later
    preload(6'd5, 32'd10);
    drive(1, 6'd5, 32'd3, 0, 6'd0, 32'd0);
    check("t2_rd_en", 64'(mem_rd_en), 1);
    check("t2_rd_addr", 64'(mem_rd_addr), 5);
    repeat (3) @(posedge clk);
    #1;
    check("t2_wr_en", 64'(mem_wr_en), 1);
    check("t2_wr_addr", 64'(mem_wr_addr), 5);
`ifdef UPDATE_MIN_EN
    check("t2_wr_data", 64'(mem_wr_data), 3);
`else
    check("t2_wr_data", 64'(mem_wr_data), 13);
`endif
    check("t2_apply_cnt", 64'(ApplyCount), 1);
    wait_idle("t2");

    // Four hits on one vertex back to back
    preload(6'd7, 32'd0);
    wr_cycles.delete();
    drive(1, 6'd7, 32'd1, 1, 6'd7, 32'd1);
    drive(1, 6'd7, 32'd1, 1, 6'd7, 32'd1);
    wait_idle("t3");
    check("t3_nwr", 64'(wr_cycles.size()), 4);
    if (wr_cycles.size() == 4) check("t3_span", 64'(wr_cycles[3] - wr_cycles[0]), 3);

    // Saturating the queue
    saw_low = 0;
    wr_cycles.delete();
    for (int i = 0; i < 20; i++)
      drive(1, 6'(20 + 2 * i), $urandom, 1, 6'(21 + 2 * i), $urandom);
    check("t4_inready_low", 64'(saw_low), 1);
    wait_idle("t4");
    check("t4_nwr", 64'(wr_cycles.size()), 40);

    // Lane A invalid
    preload(6'd9, 32'd1);
    wr_cycles.delete();
    drive(0, 6'd11, 32'd77, 1, 6'd9, 32'd4);
    wait_idle("t5");
    check("t5_nwr", 64'(wr_cycles.size()), 1);

    // Relaxation-style sequence on one vertex
    preload(6'd2, 32'd10);
    drive(1, 6'd2, 32'd3, 0, 6'd0, 32'd0);
    drive(1, 6'd2, 32'd12, 0, 6'd0, 32'd0);
    wait_idle("t6");

    // Random traffic over a small address set to stress forwarding
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 6'($urandom_range(0, 7)), $urandom,
            1'($urandom), 6'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1;
      end
    end
    wait_idle("rand");
    for (int a = 0; a < int'(MEM_N); a++) check("mem_final", 64'(mem[a]), 64'(ref_mem[a]));

    // Reset in the middle of traffic drops everything in flight
    for (int i = 0; i < 6; i++)
      drive(1, 6'($urandom_range(0, 7)), $urandom, 1, 6'($urandom_range(0, 7)), $urandom);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t1");
    exp_q.delete();
    n_acc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wr_cycles.delete();
    repeat (20) @(posedge clk);
    #1;
    check("t1_no_wr", 64'(wr_cycles.size()), 0);
    check("t1_apply_cnt", 64'(ApplyCount), 0);
    preload_all();
    for (int i = 0; i < 50; i++)
      drive(1'($urandom), 6'($urandom_range(0, 7)), $urandom,
            1'($urandom), 6'($urandom_range(0, 7)), $urandom);
    wait_idle("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
